aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES-128 inverse cipher (decryption) core; the receive-side counterpart to the encryption datapath built from AddRoundKey, state register and MixColumns blocks. Accepts one 128-bit ciphertext block plus the full expanded key schedule over a valid/ready handshake. Runs the FIPS-197 inverse cipher at one round per clock and presents the plaintext on a valid/ready output port.

## Interface
- No parameters; AES-128 only (Nr = 10).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: ciphertext block offered.
- `in_ready` out 1: core accepts a block; high only in IDLE.
- `in_block` in 128: ciphertext; `[127:120]` = byte 0 (s0,0), column-major per FIPS-197.
- `roundkey` in 1408: expanded key schedule, 176 bytes; round key r occupies `[1407-128*r -: 128]`, so rk0 is `[1407:1280]` and rk10 is `[127:0]`.
- `out_valid` out 1: plaintext available.
- `out_ready` in 1: downstream accepts plaintext.
- `out_block` out 128: plaintext, same byte order as `in_block`.

## Operation
- FSM states: IDLE, ROUND, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: state <= `in_block ^ rk10`, rnd <= 9, go to ROUND.
- **ROUND**, one round per clock:
  - rnd 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]), then rnd decrements.
  - rnd == 0: state <= InvSubBytes(InvShiftRows(state)) ^ rk0; go to DONE.
- **DONE**
  - `out_valid` = 1, `out_block` = state.
  - On `out_ready`: go to IDLE.
  - State register is held, not cleared.
- **InvSubBytes**: per-byte inverse S-box.
  - Inverse affine transform, then GF(2^8) multiplicative inverse modulo x^8+x^4+x^3+x+1, with 0 mapping to 0.
  - Implemented as a combinational function; the result must equal the FIPS-197 inverse S-box table for all 256 inputs.
- **InvMixColumns**: per-column multiply by {0e,0b,0d,09}; xtime reduction uses 0x1b.
- **InvShiftRows**: row r rotated right by r bytes.
- `in_block` and `in_valid` are ignored outside IDLE.
- No back-pressure inside ROUND.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_block` = 0, FSM = IDLE, rnd = 0, state = 0.
- Latency: `out_valid` rises exactly 11 clock edges after the accept edge (1 load edge + 10 round edges).
- `out_valid` stays high with `out_block` stable until the first edge where `out_ready` = 1. `in_ready` returns to 1 on the next cycle.
- `out_ready` sampled high on the same edge that `out_valid` rises does not complete a transfer; the transfer completes on the first edge where both are high.
- Minimum accept-to-accept spacing is 13 cycles.
- `in_valid` asserted while `out_valid` is pending is not accepted; the upstream must hold `in_valid` until `in_ready`.
- `reset` asserted in any state aborts the operation immediately and restores the reset values; no partial output is emitted.
- Without key latching, `roundkey` must be stable from the accept edge through the last ROUND edge.

## Configuration
- Macro: `AES_INV_KEY_LATCH_EN`.
- **Defined**:
  - A 1408-bit key register captures `roundkey` on the accept edge; all rounds use the captured copy.
  - `roundkey` may change freely after the accept edge.
  - The key register resets to 0.
- **Undefined**:
  - No key register; rounds read `roundkey` directly.
  - The stability rule in Timing applies.
  - Saves 1408 flops.

## Test plan
- **FIPS-197 C.1 vector.**
  - Stimulus: `in_block` = 69c4e0d86a7b0430d8cdb78070b4c55a, with the expanded schedule of key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5).
  - Required: `out_block` = 00112233445566778899aabbccddeeff; `out_valid` rises 11 edges after accept.
- **Appendix B vector.**
  - Stimulus: `in_block` = 3925841d02dc09fbdc118597196a0b32, with the key 2b7e151628aed2a6abf7158809cf4f3c expanded.
  - Required: `out_block` = 3243f6a8885a308d313198a2e0370734.
- **Output back-pressure.**
  - Stimulus: hold `out_ready` = 0 for 20 cycles after `out_valid`.
  - Required: `out_block` stable, `in_ready` = 0 throughout; a single transfer occurs when `out_ready` = 1.
- **Back-to-back blocks.**
  - Stimulus: `in_valid` held high with two blocks and `out_ready` tied to 1.
  - Required: the second accept occurs exactly 13 cycles after the first; both outputs are correct.
- **Reset mid-operation.**
  - Stimulus: assert `reset` at ROUND rnd = 5.
  - Required: outputs return to reset values immediately; a subsequent C.1 run still produces the correct result.
- **Key latching.**
  - Stimulus: with `AES_INV_KEY_LATCH_EN` defined, change `roundkey` to all-ones one cycle after accept.
  - Required: the result still equals the C.1 plaintext.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 inverse cipher, one round per clock.
// Optional macro AES_INV_KEY_LATCH_EN captures the key schedule on accept.
module aes_inv_cipher (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_block,
  input  logic [1407:0] roundkey,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  logic [3:0]    r_rnd;
  logic [3:0]    w_rnd_nxt;
  logic [127:0]  r_state;
  logic [127:0]  w_state_nxt;
  logic [1407:0] w_keys;
  logic [127:0]  w_rk;
  logic [127:0]  w_isr;
  logic [127:0]  w_isb;
  logic [127:0]  w_ark;
  logic [127:0]  w_imc;
  logic          w_accept;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 via a short addition chain; 0 maps to 0 naturally
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  // inverse affine (rotations 1,3,6 xor 0x05) followed by field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  assign w_accept = in_valid & (r_fsm == IDLE);

`ifdef AES_INV_KEY_LATCH_EN
  logic [1407:0] r_key;

  // capture the whole schedule so upstream may change it after accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_key <= '0;
    else if (w_accept) r_key <= roundkey;
  end

  assign w_keys = r_key;
`else
  assign w_keys = roundkey;
`endif

  assign w_rk = w_keys[1407 - 128 * int'(r_rnd) -: 128];

  // InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    w_isr = '0;
    w_isb = '0;
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[127 - 8 * (r + 4 * c) -: 8] =
          r_state[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      w_isb[127 - 8 * k -: 8] = inv_sbox(w_isr[127 - 8 * k -: 8]);
    end
    w_ark = w_isb ^ w_rk;
    for (int c = 0; c < 4; c++) begin
      a0 = w_ark[127 - 32 * c -: 8];
      a1 = w_ark[119 - 32 * c -: 8];
      a2 = w_ark[111 - 32 * c -: 8];
      a3 = w_ark[103 - 32 * c -: 8];
      w_imc[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                               ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      w_imc[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                               ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      w_imc[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                               ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      w_imc[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                               ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  end

  // FSM next state
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = ROUND;
      ROUND:   if (r_rnd == 4'd0) w_fsm_nxt = DONE;
      DONE:    if (out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
  end

  // datapath next values; the last round skips InvMixColumns
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    case (r_fsm)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_block ^ roundkey[127:0];
          w_rnd_nxt   = 4'd9;
        end
      end
      ROUND: begin
        if (r_rnd == 4'd0) begin
          w_state_nxt = w_ark;
        end else begin
          w_state_nxt = w_imc;
          w_rnd_nxt   = r_rnd - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // datapath registers; held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_rnd   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
    end
  end

  assign out_block = r_state;
endmodule
